serial_cmd_engine: RTL and testbench

Byte-oriented command decoder between the UART rx/tx pair and the trigger-board datapath. It is the parametrised successor of the board's serial processor:
- histogram channel count, counter width and delay-counter depth are generic;
- captures histograms as an atomic snapshot;
- times out stalled argument bytes;
- supports multi-step PLL phase shifts on a selectable counter;
- flags unknown commands.

---
 rtl/serial_cmd_engine_if.sv | 25 ++
 rtl/serial_cmd_engine.sv | 271 +++++++++++++++++++++++++++
 tb/tb_serial_cmd_engine.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_cmd_engine_if.sv
// UART-side byte handshake between the receiver/transmitter pair and the command engine.
// master = command engine, slave = UART pair (or bench).
interface serial_cmd_engine_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (
        input  rx_ready,
        input  rx_data,
        input  tx_busy,
        output tx_start,
        output tx_data
    );

    modport slave (
        output rx_ready,
        output rx_data,
        output tx_busy,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/serial_cmd_engine.sv
// Byte-oriented command decoder: takes commands from the UART, drives board configuration,
// PLL phase stepping and clock switching, and streams histogram / delay-counter snapshots back.
module serial_cmd_engine #(
    parameter int NHIST      = 8,
    parameter int HIST_W     = 32,
    parameter int NDLY       = 16,
    parameter int DLY_W      = 3,
    parameter int FW_VERSION = 4,
    parameter int RX_TIMEOUT = 1000000,
    parameter int SW_CYCLES  = 8,
    parameter int SCAN_HALF  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    serial_cmd_engine_if.master     uart,
    output logic [7:0]              readdata,
    output logic [7:0]              calibticks,
    output logic [7:0]              histostosend,
    output logic                    enable_outputs,
    output logic [2:0]              phasecounterselect,
    output logic                    phaseupdown,
    output logic                    phasestep,
    output logic                    scanclk,
    output logic                    clkswitch,
    input  logic [NHIST*HIST_W-1:0] histos,
    output logic                    resethist,
    input  logic [NDLY*DLY_W-1:0]   delaycounter,
    input  logic                    activeclock,
    output logic                    cmd_error
);

    localparam int HIST_BYTES = NHIST * HIST_W / 8;
    localparam int MAX_LEN    = (HIST_BYTES > NDLY) ? HIST_BYTES : NDLY;
    localparam int IDX_W      = $clog2(MAX_LEN + 1);
    localparam int TO_W       = $clog2(RX_TIMEOUT + 1);
    localparam int SW_W       = $clog2(SW_CYCLES + 1);
    localparam int HALF_W     = $clog2(SCAN_HALF + 1);

    typedef enum logic [3:0] {
        IDLE, ARGS, DECODE, SNAP, CLR, TX_LOAD, TX_WAIT, CLKSW, PLLSTEP
    } state_t;

    typedef enum logic [1:0] {SRC_VER, SRC_ACT, SRC_DLY, SRC_HIST} src_t;

    state_t                  state_reg, state_next;
    logic [7:0]              readdata_reg, calibticks_reg, histostosend_reg;
    logic                    enable_outputs_reg, phaseupdown_reg, phasestep_reg;
    logic                    scanclk_reg, clkswitch_reg, cmd_error_reg;
    logic [2:0]              phase_sel_reg;
    logic                    tx_start_reg;
    logic [7:0]              tx_data_reg;
    logic [1:0]              nargs_reg, arg_idx_reg;
    logic [7:0]              arg0_reg, arg1_reg;
    logic [TO_W-1:0]         to_cnt_reg;
    logic [NHIST*HIST_W-1:0] snap_reg;
    src_t                    src_reg;
    logic [IDX_W-1:0]        len_reg, idx_reg;
    logic [SW_W-1:0]         sw_cnt_reg;
    logic [7:0]              steps_reg;
    logic [HALF_W-1:0]       half_cnt_reg;
    logic [2:0]              tog_cnt_reg;

    logic                    arg_last, timeout_hit, last_byte, sw_done, half_done, step_done;
    logic [7:0]              tx_byte;
    logic [7:0]              hist_bytes [HIST_BYTES];
    logic [7:0]              dly_bytes  [NDLY];

    // Channel 0 sits in the LSBs, so the LSB-first byte stream is just the bus sliced in order.
    generate
        for (genvar gi = 0; gi < HIST_BYTES; gi++) begin : g_hist_bytes
            assign hist_bytes[gi] = snap_reg[gi*8 +: 8];
        end
        for (genvar gi = 0; gi < NDLY; gi++) begin : g_dly_bytes
            assign dly_bytes[gi] = 8'(delaycounter[gi*DLY_W +: DLY_W]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (uart.rx_ready) begin
                if (uart.rx_data == 8'd1 || uart.rx_data == 8'd2 || uart.rx_data == 8'd13)
                    state_next = ARGS;
                else
                    state_next = DECODE;
            end
            ARGS: begin
                if (uart.rx_ready) begin
                    if (arg_last) state_next = DECODE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DECODE: begin
                case (readdata_reg)
                    8'd0, 8'd8, 8'd11: state_next = TX_LOAD;
                    8'd4:              state_next = CLKSW;
                    8'd5, 8'd12:       state_next = PLLSTEP;
                    8'd10:             state_next = SNAP;
                    8'd13:             state_next = (arg1_reg != 8'd0) ? PLLSTEP : IDLE;
                    default:           state_next = IDLE;
                endcase
            end
            SNAP:    state_next = CLR;
            CLR:     state_next = TX_LOAD;
            TX_LOAD: if (!uart.tx_busy) state_next = TX_WAIT;
            TX_WAIT: state_next = last_byte ? IDLE : TX_LOAD;
            CLKSW:   if (sw_done) state_next = IDLE;
            PLLSTEP: if (step_done && steps_reg == 8'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        arg_last    = (arg_idx_reg + 2'd1) == nargs_reg;
        timeout_hit = to_cnt_reg == TO_W'(RX_TIMEOUT - 1);
        last_byte   = idx_reg == (len_reg - 1'b1);
        sw_done     = sw_cnt_reg == SW_W'(SW_CYCLES - 1);
        half_done   = half_cnt_reg == HALF_W'(SCAN_HALF - 1);
        step_done   = (state_reg == PLLSTEP) && half_done && (tog_cnt_reg == 3'd7);
        resethist   = state_reg == CLR;
        tx_byte     = 8'h00;
        case (src_reg)
            SRC_VER: tx_byte = 8'(FW_VERSION);
            SRC_ACT: tx_byte = {7'b0, activeclock};
            SRC_DLY: begin
                for (int i = 0; i < NDLY; i++)
                    if (idx_reg == IDX_W'(i)) tx_byte = dly_bytes[i];
            end
            default: begin
                for (int i = 0; i < HIST_BYTES; i++)
                    if (idx_reg == IDX_W'(i)) tx_byte = hist_bytes[i];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            readdata_reg       <= 8'd0;
            calibticks_reg     <= 8'd10;
            histostosend_reg   <= 8'd0;
            enable_outputs_reg <= 1'b0;
            phase_sel_reg      <= 3'd0;
            phaseupdown_reg    <= 1'b1;
            phasestep_reg      <= 1'b0;
            scanclk_reg        <= 1'b0;
            clkswitch_reg      <= 1'b0;
            cmd_error_reg      <= 1'b0;
            tx_start_reg       <= 1'b0;
            tx_data_reg        <= 8'd0;
            nargs_reg          <= 2'd0;
            arg_idx_reg        <= 2'd0;
            arg0_reg           <= 8'd0;
            arg1_reg           <= 8'd0;
            to_cnt_reg         <= '0;
            snap_reg           <= '0;
            src_reg            <= SRC_VER;
            len_reg            <= '0;
            idx_reg            <= '0;
            sw_cnt_reg         <= '0;
            steps_reg          <= 8'd0;
            half_cnt_reg       <= '0;
            tog_cnt_reg        <= 3'd0;
        end else begin
            tx_start_reg  <= 1'b0;
            cmd_error_reg <= 1'b0;
            case (state_reg)
                IDLE: if (uart.rx_ready) begin
                    readdata_reg <= uart.rx_data;
                    arg_idx_reg  <= 2'd0;
                    to_cnt_reg   <= '0;
                    nargs_reg    <= (uart.rx_data == 8'd13) ? 2'd2 : 2'd1;
                end
                ARGS: begin
                    if (uart.rx_ready) begin
                        if (arg_idx_reg == 2'd0) arg0_reg <= uart.rx_data;
                        else                     arg1_reg <= uart.rx_data;
                        arg_idx_reg <= arg_idx_reg + 2'd1;
                        to_cnt_reg  <= '0;
                    end else if (timeout_hit) begin
                        cmd_error_reg <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                DECODE: begin
                    idx_reg      <= '0;
                    sw_cnt_reg   <= '0;
                    half_cnt_reg <= '0;
                    tog_cnt_reg  <= 3'd0;
                    case (readdata_reg)
                        8'd0:  begin src_reg <= SRC_VER;  len_reg <= IDX_W'(1); end
                        8'd1:  calibticks_reg   <= arg0_reg;
                        8'd2:  histostosend_reg <= arg0_reg;
                        8'd3:  enable_outputs_reg <= ~enable_outputs_reg;
                        8'd4:  clkswitch_reg <= 1'b1;
                        8'd5:  begin
                            phase_sel_reg <= 3'b000;
                            steps_reg     <= 8'd1;
                            phasestep_reg <= 1'b1;
                            scanclk_reg   <= 1'b0;
                        end
                        8'd6, 8'd7: ;
                        8'd8:  begin src_reg <= SRC_ACT;  len_reg <= IDX_W'(1); end
                        8'd9:  phaseupdown_reg <= ~phaseupdown_reg;
                        8'd10: begin src_reg <= SRC_HIST; len_reg <= IDX_W'(HIST_BYTES); end
                        8'd11: begin src_reg <= SRC_DLY;  len_reg <= IDX_W'(NDLY); end
                        8'd12: begin
                            phase_sel_reg <= 3'b011;
                            steps_reg     <= 8'd1;
                            phasestep_reg <= 1'b1;
                            scanclk_reg   <= 1'b0;
                        end
                        8'd13: if (arg1_reg != 8'd0) begin
                            phase_sel_reg <= arg0_reg[2:0];
                            steps_reg     <= arg1_reg;
                            phasestep_reg <= 1'b1;
                            scanclk_reg   <= 1'b0;
                        end
                        default: cmd_error_reg <= 1'b1;
                    endcase
                end
                SNAP: snap_reg <= histos;
                TX_LOAD: if (!uart.tx_busy) begin
                    tx_start_reg <= 1'b1;
                    tx_data_reg  <= tx_byte;
                end
                TX_WAIT: idx_reg <= idx_reg + 1'b1;
                CLKSW: begin
                    if (sw_done) clkswitch_reg <= 1'b0;
                    else         sw_cnt_reg    <= sw_cnt_reg + 1'b1;
                end
                PLLSTEP: begin
                    // Eight scanclk toggles per step; phasestep covers the first six.
                    if (half_done) begin
                        half_cnt_reg <= '0;
                        scanclk_reg  <= ~scanclk_reg;
                        tog_cnt_reg  <= tog_cnt_reg + 3'd1;
                        if (tog_cnt_reg == 3'd5) phasestep_reg <= 1'b0;
                        if (tog_cnt_reg == 3'd7) begin
                            steps_reg <= steps_reg - 8'd1;
                            if (steps_reg != 8'd1) phasestep_reg <= 1'b1;
                        end
                    end else begin
                        half_cnt_reg <= half_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign uart.tx_start      = tx_start_reg;
    assign uart.tx_data       = tx_data_reg;
    assign readdata           = readdata_reg;
    assign calibticks         = calibticks_reg;
    assign histostosend       = histostosend_reg;
    assign enable_outputs     = enable_outputs_reg;
    assign phasecounterselect = phase_sel_reg;
    assign phaseupdown        = phaseupdown_reg;
    assign phasestep          = phasestep_reg;
    assign scanclk            = scanclk_reg;
    assign clkswitch          = clkswitch_reg;
    assign cmd_error          = cmd_error_reg;

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Scoreboard bench for serial_cmd_engine: stimulus pushes expected tx bytes, a monitor
// pops and compares on every tx_start and tallies error, resethist and PLL activity.
module tb_serial_cmd_engine;
    localparam int NHIST = 8;
    localparam int HIST_W = 32;
    localparam int NDLY = 16;
    localparam int DLY_W = 3;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    serial_cmd_engine_if bus();

    logic [7:0]              readdata, calibticks, histostosend;
    logic                    enable_outputs, phaseupdown, phasestep, scanclk, clkswitch;
    logic [2:0]              phasecounterselect;
    logic [NHIST*HIST_W-1:0] histos;
    logic                    resethist, activeclock, cmd_error;
    logic [NDLY*DLY_W-1:0]   delaycounter;

    serial_cmd_engine #(
        .NHIST(NHIST), .HIST_W(HIST_W), .NDLY(NDLY), .DLY_W(DLY_W),
        .FW_VERSION(4), .RX_TIMEOUT(TO), .SW_CYCLES(8), .SCAN_HALF(16)
    ) dut (
        .clk(clk), .rstn(rstn), .uart(bus),
        .readdata(readdata), .calibticks(calibticks), .histostosend(histostosend),
        .enable_outputs(enable_outputs), .phasecounterselect(phasecounterselect),
        .phaseupdown(phaseupdown), .phasestep(phasestep), .scanclk(scanclk),
        .clkswitch(clkswitch), .histos(histos), .resethist(resethist),
        .delaycounter(delaycounter), .activeclock(activeclock), .cmd_error(cmd_error)
    );

    int checks = 0;
    int errors = 0;
    byte unsigned exp_q[$];
    int tx_seen = 0, err_seen = 0, rh_seen = 0, rh_tx = -1;
    int toggles = 0, tog_ps = 0, ps_rises = 0;
    logic prev_scan = 1'b0, prev_ps = 1'b0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        $display("rx byte %02h", b);
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input int target, input int budget, input string name);
        int n = 0;
        while (tx_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(tx_seen), 64'(target));
    endtask

    // UART transmitter model: busy for 5 cycles after each tx_start.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && bus.tx_start) busy_cnt = 5;
            else if (busy_cnt > 0) busy_cnt--;
            bus.tx_busy = (busy_cnt != 0);
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (bus.tx_start) begin
                    tx_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx: got tx_data=%02h, required no transmission", bus.tx_data);
                    end else begin
                        byte unsigned e;
                        e = exp_q.pop_front();
                        $display("tx byte %02h (expected %02h)", bus.tx_data, e);
                        check("tx_data", 64'(bus.tx_data), 64'(e));
                    end
                end
                if (cmd_error) err_seen++;
                if (resethist) begin
                    rh_seen++;
                    rh_tx = tx_seen;
                end
                if (scanclk != prev_scan) begin
                    toggles++;
                    if (prev_ps) tog_ps++;
                end
                if (phasestep && !prev_ps) ps_rises++;
            end
            prev_scan = scanclk;
            prev_ps   = phasestep;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        byte unsigned hist_head [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        int base, e0, r0, n;

        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        histos       = '0;
        delaycounter = '0;
        activeclock  = 1'b0;
        idle(3);
        check("rst_tx_start", 64'(bus.tx_start), 0);
        check("rst_tx_data", 64'(bus.tx_data), 0);
        check("rst_readdata", 64'(readdata), 0);
        check("rst_calibticks", 64'(calibticks), 10);
        check("rst_histostosend", 64'(histostosend), 0);
        check("rst_enable", 64'(enable_outputs), 0);
        check("rst_select", 64'(phasecounterselect), 0);
        check("rst_updown", 64'(phaseupdown), 1);
        check("rst_phasestep", 64'(phasestep), 0);
        check("rst_scanclk", 64'(scanclk), 0);
        check("rst_clkswitch", 64'(clkswitch), 0);
        check("rst_resethist", 64'(resethist), 0);
        check("rst_cmd_error", 64'(cmd_error), 0);
        rstn = 1'b1;
        idle(2);

        // Firmware version
        exp_q.push_back(8'd4);
        base = tx_seen;
        send(8'h00);
        wait_tx(base + 1, 40, "fw_tx_count");
        idle(10);
        check("fw_single_tx", 64'(tx_seen), 64'(base + 1));
        check("fw_readdata", 64'(readdata), 0);

        // Argument timeout
        e0 = err_seen;
        send(8'h01);
        idle(TO + 20);
        check("timeout_err", 64'(err_seen), 64'(e0 + 1));
        check("timeout_calib", 64'(calibticks), 10);
        exp_q.push_back(8'd4);
        base = tx_seen;
        send(8'h00);
        wait_tx(base + 1, 40, "post_timeout_fw");

        // Argument arriving just inside the timeout window
        e0 = err_seen;
        send(8'h02);
        idle(TO - 5);
        send(8'h05);
        idle(5);
        check("late_arg_histosel", 64'(histostosend), 5);
        check("late_arg_no_err", 64'(err_seen), 64'(e0));

        // calibticks
        base = tx_seen;
        send(8'h01);
        send(8'h07);
        idle(5);
        check("calib_value", 64'(calibticks), 7);
        check("calib_no_tx", 64'(tx_seen), 64'(base));
        check("calib_no_err", 64'(err_seen), 64'(e0));

        // Toggles
        send(8'h03);
        send(8'h09);
        idle(3);
        check("enable_toggle", 64'(enable_outputs), 1);
        check("updown_toggle", 64'(phaseupdown), 0);

        // Active clock readback
        activeclock = 1'b1;
        exp_q.push_back(8'd1);
        base = tx_seen;
        send(8'h08);
        wait_tx(base + 1, 40, "activeclock_tx");

        // Delay counters
        for (int i = 0; i < NDLY; i++) begin
            delaycounter[i*DLY_W +: DLY_W] = 3'(i);
            exp_q.push_back(8'(i % 8));
        end
        base = tx_seen;
        send(8'h0B);
        wait_tx(base + NDLY, 400, "delay_tx_count");

        // Histogram snapshot with slow transmitter
        histos = '0;
        histos[31:0]  = 32'h11223344;
        histos[63:32] = 32'hAABBCCDD;
        for (int i = 0; i < 8; i++) exp_q.push_back(hist_head[i]);
        for (int i = 8; i < 32; i++) exp_q.push_back(8'h00);
        base = tx_seen;
        r0 = rh_seen;
        send(8'h0A);
        n = 0;
        while (rh_seen == r0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        histos = '1;
        wait_tx(base + 32, 800, "hist_tx_count");
        idle(10);
        check("hist_resethist_once", 64'(rh_seen - r0), 1);
        check("hist_resethist_before_tx", 64'(rh_tx), 64'(base));
        check("hist_no_extra_tx", 64'(tx_seen), 64'(base + 32));

        // PLL multi-step on C1
        toggles = 0; tog_ps = 0; ps_rises = 0;
        send(8'h0D);
        send(8'h03);
        send(8'h02);
        idle(2 * 8 * 16 + 40);
        check("pll_select", 64'(phasecounterselect), 3);
        check("pll_toggles", 64'(toggles), 16);
        check("pll_toggles_with_step", 64'(tog_ps), 12);
        check("pll_step_pulses", 64'(ps_rises), 2);
        check("pll_scanclk_low", 64'(scanclk), 0);
        check("pll_phasestep_low", 64'(phasestep), 0);
        check("pll_updown_kept", 64'(phaseupdown), 0);

        // Zero-count step request
        toggles = 0; ps_rises = 0;
        send(8'h0D);
        send(8'h00);
        send(8'h00);
        idle(60);
        check("pll0_toggles", 64'(toggles), 0);
        check("pll0_pulses", 64'(ps_rises), 0);

        // Unknown command
        e0 = err_seen;
        base = tx_seen;
        send(8'hFF);
        idle(10);
        check("badcmd_err", 64'(err_seen), 64'(e0 + 1));
        check("badcmd_no_tx", 64'(tx_seen), 64'(base));

        // Reset in the middle of a histogram transfer
        histos = '0;
        histos[31:0]  = 32'h11223344;
        histos[63:32] = 32'hAABBCCDD;
        for (int i = 0; i < 8; i++) exp_q.push_back(hist_head[i]);
        for (int i = 8; i < 32; i++) exp_q.push_back(8'h00);
        base = tx_seen;
        send(8'h0A);
        wait_tx(base + 4, 200, "pre_reset_tx");
        rstn = 1'b0;
        #1;
        check("midrst_tx_start", 64'(bus.tx_start), 0);
        check("midrst_calibticks", 64'(calibticks), 10);
        check("midrst_enable", 64'(enable_outputs), 0);
        check("midrst_updown", 64'(phaseupdown), 1);
        check("midrst_select", 64'(phasecounterselect), 0);
        check("midrst_resethist", 64'(resethist), 0);
        exp_q.delete();
        idle(3);
        rstn = 1'b1;
        idle(2);
        exp_q.push_back(8'd4);
        base = tx_seen;
        send(8'h00);
        wait_tx(base + 1, 40, "post_reset_fw");
        idle(10);
        check("post_reset_single_tx", 64'(tx_seen), 64'(base + 1));
        check("queue_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
